// File: rtl/dot_acc_pkg.sv
// Shared types and default sizing for the dot-product accumulator.
package dot_acc_pkg;
  localparam int DEF_N   = 5;
  localparam int DEF_LEN = 4;
  localparam int ACC_W   = 2 * DEF_N + $clog2(DEF_LEN);
  localparam int CNT_W   = $clog2(DEF_LEN);

  typedef enum logic {ST_ACC, ST_HOLD} state_e;
endpackage

// File: rtl/dot_product_accumulator_acc_narrow.sv
// Narrows the accumulator to the output width: clamps when SATURATE_EN is defined, wraps otherwise.
module acc_narrow #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 10
) (
  input  logic [IN_W-1:0]  acc_i,
  output logic [OUT_W-1:0] sum_o,
  output logic             ovf_o
);
`ifdef SATURATE_EN
  // The value fits only when every bit above the output sign bit matches the accumulator sign.
  always_comb begin
    sum_o = acc_i[OUT_W-1:0];
    ovf_o = 1'b0;
    if (acc_i[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){acc_i[IN_W-1]}}) begin
      ovf_o = 1'b1;
      sum_o = acc_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign sum_o     = acc_i[OUT_W-1:0];
  assign ovf_o     = 1'b0;
  assign unused_hi = ^acc_i[IN_W-1:OUT_W];
`endif
endmodule

// File: rtl/dot_product_accumulator.sv
// Sums LEN signed products into one dot product and presents it narrowed on a valid/ready port.
// Output narrowing saturates when SATURATE_EN is defined, otherwise wraps.
module dot_product_accumulator
  import dot_acc_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LEN   = DEF_LEN,
  parameter int OUT_W = 2 * N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic             out_ovf
);
  localparam int A_W = 2 * N + $clog2(LEN);
  localparam int C_W = $clog2(LEN);

  state_e           state_q, state_d;
  logic [C_W-1:0]   cnt_q, cnt_d;
  logic [A_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic [A_W-1:0]   acc_sum;
  logic [OUT_W-1:0] nar_sum;
  logic             nar_ovf;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  // First product of a set restarts from zero, so no explicit clear cycle is needed.
  assign acc_sum = ((cnt_q == '0) ? '0 : acc_q)
                 + {{(A_W-2*N){in_prod[2*N-1]}}, in_prod};

  acc_narrow #(.IN_W(A_W), .OUT_W(OUT_W)) u_narrow (
    .acc_i (acc_sum),
    .sum_o (nar_sum),
    .ovf_o (nar_ovf)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          acc_d = acc_sum;
          if (cnt_q == C_W'(LEN - 1)) begin
            cnt_d     = '0;
            state_d   = ST_HOLD;
            out_sum_d = nar_sum;
            out_ovf_d = nar_ovf;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      cnt_q     <= '0;
      acc_q     <= '0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end
endmodule
